// File: rtl/lzw_pkg.sv
// Shared constants and FSM encoding for the LZW byte transmitter feeder.
package lzw_pkg;

  localparam int LZW_CODE_W  = 12;
  localparam int SCLK_DIV    = 18;
  localparam int LZW_GAP_CYC = SCLK_DIV + 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    DONE_WAIT = 2'd2,
    GAP       = 2'd3
  } tx_state_t;

endpackage

// File: rtl/lzw_bit_packer.sv
// LSB-first code accumulator; emits one byte per cycle when tx_idle and a byte is ready.
// Accepts a code only while fewer than 8 bits are buffered and no flush is pending.
module lzw_bit_packer
  import lzw_pkg::*;
#(
  parameter int CODE_W = LZW_CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_vld,
  output logic              code_rdy,
  input  logic              flush_pend,
  input  logic              tx_idle,
  output logic              emit,
  output logic [7:0]        emit_byte,
  output logic              acc_empty
);

  localparam int             ACC_W   = CODE_W + 7;
  localparam logic [4:0]     CODE_W5 = 5'(CODE_W);

  logic [ACC_W-1:0] acc;
  logic [4:0]       acc_cnt;
  logic             full_byte;
  logic             part_byte;
  logic             accept;

  assign full_byte = (acc_cnt >= 5'd8);
  assign part_byte = flush_pend && (acc_cnt != 5'd0) && !full_byte;
  assign code_rdy  = !full_byte && !flush_pend;
  assign accept    = code_vld && code_rdy;
  assign emit      = tx_idle && (full_byte || part_byte);
  assign emit_byte = acc[7:0];
  assign acc_empty = (acc_cnt == 5'd0);

  // Bits above acc_cnt are always zero, so a partial byte is already zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      acc     <= acc | ({7'b0, code_in} << acc_cnt);
      acc_cnt <= acc_cnt + CODE_W5;
    end else if (emit) begin
      if (full_byte) begin
        acc     <= acc >> 8;
        acc_cnt <= acc_cnt - 5'd8;
      end else begin
        acc     <= '0;
        acc_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lzw_byte_tx.sv
// Packs LZW codes into bytes for the serial transmitter (start_xmt/xmt_done handshake, GAP_CYC idle gap).
// Optional LZW_BYTE_TX_CNT_EN adds tx_count; code_rdy drops while bytes are buffered or a flush is pending.
module lzw_byte_tx
  import lzw_pkg::*;
#(
  parameter int CODE_W  = LZW_CODE_W,
  parameter int GAP_CYC = LZW_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_vld,
  output logic              code_rdy,
  input  logic              flush,
  output logic              flush_done,
  input  logic              xmt_done,
  output logic              start_xmt,
  output logic [7:0]        xmt_byte,
  output logic              busy
`ifdef LZW_BYTE_TX_CNT_EN
  ,
  output logic [15:0]       tx_count
`endif
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_last;
  logic             flush_pend;
  logic             tx_idle;
  logic             emit;
  logic [7:0]       emit_byte;
  logic             acc_empty;

  lzw_bit_packer #(.CODE_W(CODE_W)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_vld  (code_vld),
    .code_rdy  (code_rdy),
    .flush_pend(flush_pend),
    .tx_idle   (tx_idle),
    .emit      (emit),
    .emit_byte (emit_byte),
    .acc_empty (acc_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (emit) state_nxt = SEND;
      SEND:      state_nxt = DONE_WAIT;
      DONE_WAIT: if (xmt_done) state_nxt = GAP;
      GAP:       if (gap_last && !xmt_done) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_idle    = (state == IDLE);
    start_xmt  = (state == SEND) || (state == DONE_WAIT);
    flush_done = tx_idle && flush_pend && acc_empty;
    busy       = !acc_empty || flush_pend || !tx_idle;
  end

  // The gap count is held at its last value until the transmitter releases xmt_done.
  assign gap_last = (gap_cnt == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             gap_cnt <= '0;
    else if (state != GAP)  gap_cnt <= '0;
    else if (!gap_last)     gap_cnt <= gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          flush_pend <= 1'b0;
    else if (flush_done) flush_pend <= 1'b0;
    else if (flush)      flush_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    xmt_byte <= 8'h00;
    else if (emit) xmt_byte <= emit_byte;
  end

`ifdef LZW_BYTE_TX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tx_count <= 16'h0000;
    else if (flush_done) tx_count <= 16'h0000;
    else if (emit)       tx_count <= tx_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_lzw_byte_tx.sv
// Bench for lzw_byte_tx: vector table of code sequences plus hand-written gap, backpressure and reset cases.
module tb_lzw_byte_tx;
  import lzw_pkg::*;

  localparam int CODE_W  = 12;
  localparam int GAP_CYC = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CODE_W-1:0] code_in;
  logic              code_vld;
  logic              code_rdy;
  logic              flush;
  logic              flush_done;
  logic              xmt_done;
  logic              start_xmt;
  logic [7:0]        xmt_byte;
  logic              busy;
`ifdef LZW_BYTE_TX_CNT_EN
  logic [15:0]       tx_count;
`endif

  lzw_byte_tx #(.CODE_W(CODE_W), .GAP_CYC(GAP_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_vld  (code_vld),
    .code_rdy  (code_rdy),
    .flush     (flush),
    .flush_done(flush_done),
    .xmt_done  (xmt_done),
    .start_xmt (start_xmt),
    .xmt_byte  (xmt_byte),
    .busy      (busy)
`ifdef LZW_BYTE_TX_CNT_EN
    ,
    .tx_count  (tx_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial transmitter model and output monitor.
  int   xmt_delay = 40;
  int   done_hold = 1;
  int   tx_timer  = 0;
  int   hold_cnt  = 0;
  int   last_fall = -1;
  int   n_rx      = 0;
  logic prev_start = 1'b0;

  initial begin
    xmt_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        xmt_done   = 1'b0;
        tx_timer   = 0;
        hold_cnt   = 0;
        prev_start = 1'b0;
        last_fall  = -1;
      end else begin
        if (start_xmt && !prev_start) begin
          n_rx++;
          chk("done_low_at_start", xmt_done, 0);
          if (last_fall >= 0) chk("gap_min_cycles", (cyc - last_fall) >= GAP_CYC, 1);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", xmt_byte);
          end else begin
            chk("byte", xmt_byte, exp_q.pop_front());
          end
        end
        if (!start_xmt && prev_start) last_fall = cyc;
        if (start_xmt && !xmt_done) begin
          tx_timer++;
          if (tx_timer >= xmt_delay) xmt_done = 1'b1;
        end else if (!start_xmt && xmt_done) begin
          hold_cnt++;
          if (hold_cnt >= done_hold) begin
            xmt_done = 1'b0;
            tx_timer = 0;
            hold_cnt = 0;
          end
        end
        prev_start = start_xmt;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_code(input logic [CODE_W-1:0] c);
    int t = 0;
    code_in  = c;
    code_vld = 1'b1;
    while (!code_rdy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept_in_time", code_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("rdy_low_after_accept", code_rdy, 0);
  endtask

  task automatic do_flush();
    int t = 0;
    int rdy_bad = 0;
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    while (!flush_done && t < 20000) begin
      if (code_rdy) rdy_bad++;
      @(negedge clk);
      t++;
    end
    chk("flush_done_seen", flush_done, 1);
    chk("rdy_low_during_flush", rdy_bad, 0);
    @(negedge clk);
    chk("flush_done_one_cycle", flush_done, 0);
    chk("idle_after_flush", busy, 0);
  endtask

  typedef struct {
    int                    n_codes;
    logic [2:0][CODE_W-1:0] codes;
    int                    n_bytes;
    logic [4:0][7:0]       bytes;
    int                    dly;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rx0;
    int t;
    logic [127:0]       bits;
    logic [CODE_W-1:0]  bp_codes[8];

    vecs[0] = '{2, {12'h000, 12'h123, 12'hABC}, 3, {8'h00, 8'h00, 8'h12, 8'h3A, 8'hBC}, 2880};
    vecs[1] = '{1, {12'h000, 12'h000, 12'hABC}, 2, {8'h00, 8'h00, 8'h00, 8'h0A, 8'hBC}, 40};
    vecs[2] = '{3, {12'h001, 12'h000, 12'hFFF}, 5, {8'h00, 8'h01, 8'h00, 8'h0F, 8'hFF}, 40};
    vecs[3] = '{2, {12'h000, 12'hAAA, 12'h555}, 3, {8'h00, 8'h00, 8'hAA, 8'hA5, 8'h55}, 40};

    rst_n    = 1'b0;
    code_in  = '0;
    code_vld = 1'b0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_xmt", start_xmt, 0);
    chk("rst_xmt_byte", xmt_byte, 8'h00);
    chk("rst_code_rdy", code_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flush_done", flush_done, 0);

    // Flush on an empty, idle block completes one cycle after the pulse.
    flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    chk("empty_flush_done", flush_done, 1);
    @(negedge clk);
    chk("empty_flush_done_drop", flush_done, 0);

    for (int v = 0; v < 4; v++) begin
      xmt_delay = vecs[v].dly;
      rx0 = n_rx;
      for (int b = 0; b < vecs[v].n_bytes; b++) exp_q.push_back(vecs[v].bytes[b]);
      for (int c = 0; c < vecs[v].n_codes; c++) send_code(vecs[v].codes[c]);
      code_vld = 1'b0;
      do_flush();
      chk("vec_byte_count", n_rx - rx0, vecs[v].n_bytes);
      chk("vec_queue_empty", exp_q.size(), 0);
    end

    // xmt_done held well past the gap: the next byte must wait for it to fall.
    done_hold = 30;
    rx0 = n_rx;
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h45);
    send_code(12'h123);
    send_code(12'h456);
    code_vld = 1'b0;
    do_flush();
    chk("gap_byte_count", n_rx - rx0, 3);
    done_hold = 1;

    // Back-to-back codes: 96 bits give exactly 12 bytes, no flush needed.
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bp_codes[i] = CODE_W'($urandom);
      bits = bits | (128'(bp_codes[i]) << (CODE_W * i));
    end
    for (int b = 0; b < 12; b++) exp_q.push_back(bits[8*b +: 8]);
    rx0 = n_rx;
    for (int i = 0; i < 8; i++) send_code(bp_codes[i]);
    code_vld = 1'b0;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("bp_drained", busy, 0);
    chk("bp_byte_count", n_rx - rx0, 12);
    chk("bp_queue_empty", exp_q.size(), 0);
`ifdef LZW_BYTE_TX_CNT_EN
    chk("bp_tx_count", tx_count, 16'd12);
`endif

    // Reset while the transmitter is mid-byte.
    xmt_delay = 2880;
    exp_q.push_back(8'hA5);
    send_code(12'h5A5);
    code_vld = 1'b0;
    t = 0;
    while (!start_xmt && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_started", start_xmt, 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_start_drop", start_xmt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx0 = n_rx;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_code_rdy", code_rdy, 1);
    chk("rst_mid_xmt_byte", xmt_byte, 8'h00);
    chk("rst_mid_queue_empty", exp_q.size(), 0);
    repeat (50) @(negedge clk);
    chk("rst_mid_no_more_bytes", n_rx - rx0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lzw_byte_tx.md
Name: lzw_byte_tx

Overview:
Upstream feeder for the serial transmitter. Accepts variable-width LZW output codes over a valid/ready handshake and packs them LSB-first into a continuous bit stream. Slices the stream into bytes and hands each byte to the serial transmitter using its level-held start_xmt / xmt_done protocol. A flush request zero-pads and emits any partial final byte at end of stream.

Parameters:
CODE_W, 12, LZW code width in bits; legal range 9..16.
GAP_CYC, 20, minimum clk cycles start_xmt is held low between bytes; at least the serial clock divide (18) plus 2.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
code_in  in  CODE_W  LZW code to pack
code_vld  in  1  code_in valid
code_rdy  out  1  block can accept a code this cycle
flush  in  1  single-cycle pulse: end of stream, emit partial byte
flush_done  out  1  single-cycle pulse: flush complete, accumulator empty, transmitter idle
xmt_done  in  1  from serial transmitter: stop bit sent (level, stays high until start_xmt drops)
start_xmt  out  1  to serial transmitter: held high for the whole byte
xmt_byte  out  8  byte to transmit; stable while start_xmt is high
busy  out  1  accumulator non-empty, flush pending, or FSM not IDLE

Behaviour:
- Accumulator: acc[CODE_W+6:0] and acc_cnt (5 bits). Bits fill from bit 0 upward.
- code_rdy = (acc_cnt < 8) & !flush_pend.
- Accept when code_vld & code_rdy: acc |= code_in << acc_cnt; acc_cnt += CODE_W.
- Emit when FSM is IDLE and acc_cnt >= 8: xmt_byte <= acc[7:0]; acc >>= 8; acc_cnt -= 8; FSM moves to SEND.
- Accept and emit are mutually exclusive by construction: accept needs acc_cnt < 8, emit needs acc_cnt >= 8.
- Flush: a flush pulse sets flush_pend.
  - With flush_pend set, FSM IDLE and 1 <= acc_cnt <= 7: emit acc[7:0] with upper bits zero; acc_cnt <= 0.
  - With flush_pend set, acc_cnt == 0 and FSM IDLE: clear flush_pend and pulse flush_done for 1 cycle.
  - A flush with an empty accumulator and IDLE FSM gives flush_done 1 cycle after the pulse.
  - A flush while flush_pend is already set is ignored.
- FSM states:
  - IDLE: start_xmt = 0. Go to SEND on emit.
  - SEND: start_xmt = 1. Go to DONE_WAIT next cycle.
  - DONE_WAIT: start_xmt = 1. Go to GAP when xmt_done = 1, and drop start_xmt in that same transition.
  - GAP: start_xmt = 0. Gap counter counts GAP_CYC cycles. Return to IDLE only when the count has expired and xmt_done = 0.
- The gap guarantees the transmitter's edge detector sees start_xmt low and its bit counters clear before the next byte.
- xmt_byte changes only on an emit. It holds its value through GAP and IDLE.
- Reset values:
  - code_rdy = 1, flush_done = 0, start_xmt = 0, xmt_byte = 0x00, busy = 0.
  - acc = 0, acc_cnt = 0, flush_pend = 0, FSM = IDLE, gap counter = 0.
- Reset mid-byte: start_xmt drops asynchronously, and the partial accumulator contents are discarded.
- xmt_done high while in IDLE or SEND is ignored; only DONE_WAIT samples it.

Optional Feature:
LZW_BYTE_TX_CNT_EN
- Defined: adds output tx_count[15:0]. Reset 0. Increments on each emit and wraps 0xFFFF -> 0. Cleared on the flush_done cycle.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package lzw_pkg holds:
  - CODE_W default;
  - SCLK_DIV = 18;
  - GAP_CYC default;
  - FSM state encoding: IDLE = 2'd0, SEND = 2'd1, DONE_WAIT = 2'd2, GAP = 2'd3.
- One natural sub-module, lzw_bit_packer: accumulator, acc_cnt, code_rdy and emit datapath.
- The top level holds the FSM, gap counter, flush control and the optional counter.

Test Plan:
- Reset: hold rst_n low, then release -> start_xmt = 0, xmt_byte = 0x00, code_rdy = 1, busy = 0.
- Two-code pack: codes 0xABC then 0x123, then flush, with a transmitter model that raises xmt_done 2880 clk after the start_xmt rise -> bytes 0xBC, 0x3A, 0x12 in order, then flush_done; no padding byte.
- Partial flush: single code 0xABC, then flush -> bytes 0xBC, 0x0A, then a flush_done pulse; code_rdy stays low from the flush until flush_done.
- Gap rule: keep xmt_done high for 30 cycles after start_xmt falls -> next start_xmt rise occurs no earlier than 1 cycle after xmt_done falls, and at least GAP_CYC = 20 cycles after the fall.
- Backpressure: drive code_vld continuously with 8 codes -> code_rdy deasserts whenever acc_cnt >= 8; exactly 12 bytes are sent; no code is lost or duplicated.
- Reset mid-transfer: assert rst_n low during DONE_WAIT -> start_xmt = 0 immediately; after release, busy = 0 and code_rdy = 1.
